// File: rtl/comb_lock_pkg.sv
// Shared definitions for the A/B/C/D combination lock and its code sender:
// button symbol encoding, the sender state type, and the lock's state codes.
package comb_lock_pkg;

    // Button symbols as carried in the 2-bit code fields.
    localparam logic [1:0] BTN_A = 2'd0;
    localparam logic [1:0] BTN_B = 2'd1;
    localparam logic [1:0] BTN_C = 2'd2;
    localparam logic [1:0] BTN_D = 2'd3;

    // combination_sender sequencing states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS     = 3'd1,
        GAP       = 3'd2,
        WAIT_RESP = 3'd3,
        FINISH    = 3'd4
    } sender_state_t;

    // Lock FSM state codes: number of correct symbols seen so far, then open.
    localparam logic [2:0] LOCK_IDLE = 3'd0;
    localparam logic [2:0] LOCK_GOT1 = 3'd1;
    localparam logic [2:0] LOCK_GOT2 = 3'd2;
    localparam logic [2:0] LOCK_GOT3 = 3'd3;
    localparam logic [2:0] LOCK_OPEN = 3'd4;

endpackage

// File: rtl/btn_onehot_dec.sv
// Symbol-to-button decoder: turns a 2-bit button symbol into the {D,C,B,A}
// one-hot press vector, or all zeros when not enabled. Purely combinational.
module btn_onehot_dec
    import comb_lock_pkg::*;
(
    input  logic [1:0] sym,
    input  logic       en,
    output logic [3:0] btn
);

    // Decode the symbol; a disabled decoder drives no button at all.
    always_comb begin
        // NOTE: default assigned first so every path drives btn and no latch is inferred.
        btn = 4'b0000;
        if (en) begin
            unique case (sym)
                BTN_A: btn = 4'b0001;
                BTN_B: btn = 4'b0010;
                BTN_C: btn = 4'b0100;
                BTN_D: btn = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/combination_sender.sv
// Combination sender: replays a stored A/B/C/D code into the lock as
// single-cycle one-hot presses separated by idle gaps, then waits a bounded
// time for the lock's unlock output and reports done/success.
// Optional build macro COMBINATION_SENDER_RETRY_EN: on timeout, replay the
// code up to RETRIES more times before reporting failure; adds 'attempts'.
module combination_sender
    import comb_lock_pkg::*;
#(
    parameter int CODE_LEN   = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 8,
    parameter int RETRIES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*CODE_LEN-1:0] code,
    input  logic                  unlock,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  D,
    output logic                  busy,
    output logic                  done,
    output logic                  success
`ifdef COMBINATION_SENDER_RETRY_EN
    ,
    output logic [$clog2(RETRIES+2)-1:0] attempts
`endif
);

    localparam int IDX_W  = $clog2(CODE_LEN + 1);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CODE_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    // Reject parameter values the sequencing cannot honour.
    if (CODE_LEN < 1 || TIMEOUT < 1 || GAP_CYCLES < 0 || RETRIES < 0) begin : g_bad_params
        $error("combination_sender: illegal parameter value");
    end

    sender_state_t         state_q, next_state;
    logic [2*CODE_LEN-1:0] code_q;
    logic [2*CODE_LEN-1:0] sym_src;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic                  success_d;
    logic [1:0]            next_sym;
    logic [3:0]            next_btn;
    logic [3:0]            btn_q;
    logic                  busy_q, done_q, success_q;
    logic                  accept;
    logic                  retry;

`ifdef COMBINATION_SENDER_RETRY_EN
    localparam int ATT_W = $clog2(RETRIES + 2);
    logic [ATT_W-1:0] attempts_q;
    logic             retry_left;
    assign retry_left = (attempts_q < ATT_W'(RETRIES + 1));
`endif

    // Symbol idx of a packed code word; out-of-range indices fall back to A.
    function automatic logic [1:0] pick_sym(input logic [2*CODE_LEN-1:0] c,
                                            input logic [IDX_W-1:0]      i);
        pick_sym = BTN_A;
        for (int k = 0; k < CODE_LEN; k++) begin
            if (i == IDX_W'(k)) pick_sym = c[2*k +: 2];
        end
    endfunction

    // Next-state, next symbol index and next result.
    always_comb begin
        next_state = state_q;
        idx_d      = idx_q;
        success_d  = success_q;
        sym_src    = code_q;
        accept     = 1'b0;
        retry      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = PRESS;
                    idx_d      = '0;
                    success_d  = 1'b0;
                    // The code register loads on this same edge, so the first
                    // press decodes straight from the input.
                    sym_src    = code;
                end
            end
            PRESS: begin
                if (idx_q == LAST_IDX) begin
                    next_state = WAIT_RESP;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    next_state = (GAP_CYCLES == 0) ? PRESS : GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) next_state = PRESS;
            end
            WAIT_RESP: begin
                if (unlock) begin
                    success_d  = 1'b1;
                    next_state = FINISH;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    success_d  = 1'b0;
                    next_state = FINISH;
`ifdef COMBINATION_SENDER_RETRY_EN
                    if (retry_left) begin
                        retry      = 1'b1;
                        idx_d      = '0;
                        next_state = (GAP_CYCLES == 0) ? PRESS : GAP;
                    end
`endif
                end
            end
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        next_sym = pick_sym(sym_src, idx_d);
    end

    // Buttons are registered from the next state so a press lines up with PRESS.
    btn_onehot_dec u_dec (
        .sym (next_sym),
        .en  (next_state == PRESS),
        .btn (next_btn)
    );

    // State, counters, latched code and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            idx_q      <= '0;
            gap_cnt_q  <= '0;
            wait_cnt_q <= '0;
            btn_q      <= 4'b0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state_q    <= next_state;
            idx_q      <= idx_d;
            success_q  <= success_d;
            btn_q      <= next_btn;
            busy_q     <= (next_state == PRESS) || (next_state == GAP) ||
                          (next_state == WAIT_RESP);
            done_q     <= (next_state == FINISH);
            gap_cnt_q  <= (state_q == GAP && next_state == GAP) ? gap_cnt_q + 1'b1 : '0;
            wait_cnt_q <= (state_q == WAIT_RESP && next_state == WAIT_RESP) ?
                          wait_cnt_q + 1'b1 : '0;
            if (accept) code_q <= code;
        end
    end

`ifdef COMBINATION_SENDER_RETRY_EN
    // Attempt counter: 1 on an accepted start, +1 on every replay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            attempts_q <= '0;
        end else if (accept) begin
            attempts_q <= ATT_W'(1);
        end else if (retry) begin
            attempts_q <= attempts_q + 1'b1;
        end
    end
    assign attempts = attempts_q;
`else
    logic unused_retry;
    assign unused_retry = retry;
`endif

    assign {D, C, B, A} = btn_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign success      = success_q;

endmodule
